// File: rtl/sm_mem_arbiter_pkg.sv
// Shared encodings for the CPU fetch/data memory arbiter.
package sm_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_e;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/sm_arb_rr2.sv
// Two-way round-robin pick between fetch and data requests.
module sm_arb_rr2
  import sm_mem_arbiter_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  logic       en,
  input  arb_owner_e last_owner,
  output logic       gnt_i,
  output logic       gnt_d,
  output arb_owner_e next_owner
);

  always_comb begin
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    next_owner = last_owner;
    if (en) begin
      // On a conflict the port that did not go last wins.
      gnt_d = req_d && (!req_i || last_owner == ARB_OWN_I);
      gnt_i = req_i && (!req_d || last_owner == ARB_OWN_D);
      if (gnt_d)      next_owner = ARB_OWN_D;
      else if (gnt_i) next_owner = ARB_OWN_I;
    end
  end

endmodule

// File: rtl/sm_mem_arbiter.sv
// Serialises CPU fetch and data accesses onto one fixed-latency memory,
// one transaction outstanding, round-robin on conflicts.
module sm_mem_arbiter
  import sm_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  // Handshake: a requester raises req with its address/data and holds them
  // until gnt is seen in the same cycle; gnt is the only sampling point.
  // Exactly MEM_LAT+2 cycles after gnt the owner sees a one-cycle rvalid.

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_e        state;
  arb_owner_e        owner_q;
  arb_owner_e        last_owner;
  arb_owner_e        next_owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt;
  logic              grant_en;
  logic              gnt_i;
  logic              gnt_d;

  // Gated by rst_n so no grant leaks out while reset is held.
  assign grant_en = (state == ARB_IDLE) && rst_n;

  sm_arb_rr2 u_rr2 (
    .req_i      (i_req),
    .req_d      (d_req),
    .en         (grant_en),
    .last_owner (last_owner),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d),
    .next_owner (next_owner)
  );

  assign i_gnt   = gnt_i;
  assign d_gnt   = gnt_d;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner_q    <= ARB_OWN_I;
      last_owner <= ARB_OWN_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      cnt        <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      i_rvalid   <= 1'b0;
      i_rdata    <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt_i || gnt_d) begin
            owner_q    <= gnt_d ? ARB_OWN_D : ARB_OWN_I;
            last_owner <= next_owner;
            addr_q     <= gnt_d ? d_addr : i_addr;
            wdata_q    <= gnt_d ? d_wdata : '0;
            we_q       <= gnt_d && d_we;
            m_req      <= 1'b1;
            m_we       <= gnt_d && d_we;
            state      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          m_req <= 1'b0;
          m_we  <= 1'b0;
          cnt   <= CNT_INIT;
          state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (cnt == '0) begin
            // m_rdata is valid in this cycle; stores report zero data.
            if (owner_q == ARB_OWN_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= we_q ? '0 : m_rdata;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= m_rdata;
            end
            state <= ARB_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ARB_RESP: begin
          i_rvalid <= 1'b0;
          d_rvalid <= 1'b0;
          state    <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
